sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between a burst write
// requester and a burst read requester. Reads are preferred, but after
// MAX_RD_RUN back-to-back read grants a waiting write is let through.
module sdram_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int LEN_W      = 8,
  parameter int DATA_W     = 16,
  parameter int MAX_RD_RUN = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INIT_WAIT_200_i,
  input  logic              WR_RQ_i,
  input  logic [LEN_W-1:0]  WR_LEN_i,
  input  logic [ADDR_W-1:0] WR_ADDR_i,
  input  logic [DATA_W-1:0] WR_DATA_i,
  output logic              WR_DATA_RQ_o,
  output logic              WR_DONE_o,
  input  logic              RD_RQ_i,
  input  logic [LEN_W-1:0]  RD_LEN_i,
  input  logic [ADDR_W-1:0] RD_ADDR_i,
  output logic [DATA_W-1:0] RD_DATA_o,
  output logic              RD_DATA_EN_o,
  output logic              RD_DONE_o,
  output logic              M_WR_RQ_o,
  output logic              M_RD_RQ_o,
  output logic [LEN_W-1:0]  M_LEN_o,
  output logic [ADDR_W-1:0] M_ADDR_o,
  output logic [DATA_W-1:0] M_WDATA_o,
  input  logic              M_WR_DATA_RQ_i,
  input  logic              M_WR_END_i,
  input  logic              M_RD_END_i,
  input  logic [DATA_W-1:0] M_RDATA_i,
  input  logic              M_RDATA_EN_i
);

  typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        rd_run_reg, rd_run_next;
  logic [LEN_W-1:0]  len_reg, len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  // Remembers which direction owns the DONE cycle (1 = write).
  logic              done_wr_reg, done_wr_next;
  logic              rd_run_at_limit;

  assign rd_run_at_limit = int'(rd_run_reg) >= MAX_RD_RUN;

  // State and latched burst parameters; reset aborts any burst silently.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg   <= IDLE;
      rd_run_reg  <= 3'd0;
      len_reg     <= '0;
      addr_reg    <= '0;
      done_wr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rd_run_reg  <= rd_run_next;
      len_reg     <= len_next;
      addr_reg    <= addr_next;
      done_wr_reg <= done_wr_next;
    end
  end

  // Arbitration and burst sequencing.
  always_comb begin
    state_next   = state_reg;
    rd_run_next  = rd_run_reg;
    len_next     = len_reg;
    addr_next    = addr_reg;
    done_wr_next = done_wr_reg;
    case (state_reg)
      IDLE: begin
        if (INIT_WAIT_200_i) begin
          if (RD_RQ_i && !(WR_RQ_i && rd_run_at_limit)) begin
            len_next     = RD_LEN_i;
            addr_next    = RD_ADDR_i;
            done_wr_next = 1'b0;
            rd_run_next  = (rd_run_reg == 3'd7) ? 3'd7 : rd_run_reg + 3'd1;
            // A zero-length burst never reaches the controller.
            state_next   = (RD_LEN_i == '0) ? DONE : RD_BUSY;
          end else if (WR_RQ_i) begin
            len_next     = WR_LEN_i;
            addr_next    = WR_ADDR_i;
            done_wr_next = 1'b1;
            rd_run_next  = 3'd0;
            state_next   = (WR_LEN_i == '0) ? DONE : WR_BUSY;
          end
        end
      end
      RD_BUSY: if (M_RD_END_i) state_next = DONE;
      WR_BUSY: if (M_WR_END_i) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign M_RD_RQ_o = (state_reg == RD_BUSY);
  assign M_WR_RQ_o = (state_reg == WR_BUSY);
  assign RD_DONE_o = (state_reg == DONE) && !done_wr_reg;
  assign WR_DONE_o = (state_reg == DONE) && done_wr_reg;
  assign M_LEN_o   = len_reg;
  assign M_ADDR_o  = addr_reg;

  // Data paths pass straight through, gated by the owning direction.
  assign M_WDATA_o    = WR_DATA_i;
  assign WR_DATA_RQ_o = M_WR_DATA_RQ_i && (state_reg == WR_BUSY);
  assign RD_DATA_o    = M_RDATA_i;
  assign RD_DATA_EN_o = M_RDATA_EN_i && (state_reg == RD_BUSY);

endmodule
